// File: rtl/ff_table_bank.sv
// ---------------------------------------------------------------------------
// ff_table_bank
//
// Ping-pong waveform store feeding the feed-forward driver. One bank is
// "active" and is played back through the registered read port (mem); the
// other is the "shadow" bank that the host fills over the local bus. A commit
// request swaps the two banks, but only while no playback is running and no
// host write is in flight, so a waveform is never torn mid-play.
//
// The block also turns an external trigger into the driver's one-cycle start
// pulse and tracks the playback window (busy) until the driver presents the
// terminal address L, where L is word 0 (header) of the active bank.
//
// Ports
//   clk           system clock
//   reset         synchronous, active-high reset
//   lb_write      host write strobe (targets the shadow bank)
//   lb_addr       host write address
//   lb_data       host write data
//   commit        one-cycle swap request
//   arm           level, enables trigger acceptance
//   trig          one-cycle playback trigger
//   mem_addr      driver read address
//   mem           active-bank word at mem_addr, one cycle later
//   start         one-cycle start pulse to the driver
//   busy          playback in progress
//   bank_sel      index of the active bank
//   swap_pending  commit accepted, swap not yet executed
//   len_err       active header length invalid (L < 4 or L = all ones)
//   trig_miss     saturating count of rejected triggers
// ---------------------------------------------------------------------------
module ff_table_bank #(
    parameter int MEM_AW = 11,
    parameter int DW     = 18,
    parameter int MISS_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              lb_write,
    input  logic [MEM_AW-1:0] lb_addr,
    input  logic [DW-1:0]     lb_data,
    input  logic              commit,
    input  logic              arm,
    input  logic              trig,
    input  logic [MEM_AW-1:0] mem_addr,
    output logic [DW-1:0]     mem,
    output logic              start,
    output logic              busy,
    output logic              bank_sel,
    output logic              swap_pending,
    output logic              len_err,
    output logic [MISS_W-1:0] trig_miss
);

    localparam int DEPTH = 1 << MEM_AW;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LAUNCH = 2'd1;
    localparam logic [1:0] ST_PLAY   = 2'd2;

    localparam logic [MEM_AW-1:0] LEN_MIN  = MEM_AW'(4);
    localparam logic [MEM_AW-1:0] LEN_MAX  = {MEM_AW{1'b1}};
    localparam logic [MISS_W-1:0] MISS_SAT = {MISS_W{1'b1}};
    // Terminal-address compare is masked until this many cycles after start,
    // which hides the driver's address-0 window at the head of playback.
    localparam logic [2:0]        GUARD    = 3'd4;

    // -----------------------------------------------------------------------
    // Storage: both banks live in one RAM, the bank index is the address MSB.
    // Writes always land in the shadow half, reads always come from the
    // active half, so the two ports never touch the same half.
    // -----------------------------------------------------------------------
    logic [DW-1:0]     ram [2*DEPTH];
    logic [DW-1:0]     mem_q;
    logic [MEM_AW:0]   wr_addr;
    logic [MEM_AW:0]   rd_addr;

    logic              bank_sel_q, bank_sel_d;
    logic              swap_pending_q, swap_pending_d;
    logic [1:0]        state_q, state_d;
    logic [2:0]        elapsed_q, elapsed_d;
    logic [MISS_W-1:0] trig_miss_q, trig_miss_d;
    logic [MEM_AW-1:0] len_q, len_d;
    logic              len_err_q, len_err_d;
    logic              init_q;

    assign wr_addr = {~bank_sel_q, lb_addr};
    assign rd_addr = {bank_sel_q, mem_addr};

    always_ff @(posedge clk) begin
        if (lb_write) begin
            ram[wr_addr] <= lb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q <= '0;
        end else begin
            mem_q <= ram[rd_addr];
        end
    end

    // -----------------------------------------------------------------------
    // Header mirrors: a register copy of word 0 of each bank, kept in step
    // with host writes. This lets the length be latched on a swap without a
    // second RAM read port. Like the RAM, they are not cleared by reset.
    // -----------------------------------------------------------------------
    logic [1:0][MEM_AW-1:0] hdr_vec;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_hdr
            logic [MEM_AW-1:0] hdr_q;

            always_ff @(posedge clk) begin
                if (lb_write && (lb_addr == '0) && (bank_sel_q != 1'(gi))) begin
                    hdr_q <= lb_data[MEM_AW-1:0];
                end
            end

            assign hdr_vec[gi] = hdr_q;
        end
    endgenerate

    function automatic logic len_bad(input logic [MEM_AW-1:0] l);
        return (l < LEN_MIN) || (l == LEN_MAX);
    endfunction

    // -----------------------------------------------------------------------
    // Swap and trigger qualification
    // -----------------------------------------------------------------------
    logic busy_w;
    logic pend_eff;
    logic swap_fire;
    logic accept;
    logic terminal;

    assign busy_w    = (state_q != ST_IDLE);
    // A commit counts as pending in its own cycle, so an idle bank swaps
    // immediately and swap_pending is never seen high in that case.
    assign pend_eff  = swap_pending_q | commit;
    assign swap_fire = pend_eff & ~busy_w & ~lb_write;
    // A trigger colliding with a swap loses: the new bank's header has not
    // been checked yet.
    assign accept    = trig & arm & ~len_err_q & ~busy_w & ~swap_fire;
    assign terminal  = (state_q == ST_PLAY) && (elapsed_q >= GUARD) && (mem_addr == len_q);

    always_comb begin
        state_d   = state_q;
        elapsed_d = elapsed_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d   = ST_LAUNCH;
                    elapsed_d = '0;
                end
            end
            ST_LAUNCH: begin
                state_d   = ST_PLAY;
                elapsed_d = elapsed_q + 3'd1;
            end
            ST_PLAY: begin
                if (terminal) begin
                    state_d = ST_IDLE;
                end
                // Saturate once the guard is met; only ">= GUARD" matters.
                if (elapsed_q < GUARD) begin
                    elapsed_d = elapsed_q + 3'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        trig_miss_d = trig_miss_q;
        if (trig && !accept && (trig_miss_q != MISS_SAT)) begin
            trig_miss_d = trig_miss_q + 1'b1;
        end
    end

    always_comb begin
        bank_sel_d     = bank_sel_q ^ swap_fire;
        swap_pending_d = swap_pending_q;
        if (swap_fire) begin
            swap_pending_d = 1'b0;
        end else if (commit) begin
            swap_pending_d = 1'b1;
        end
    end

    // The length copy follows the bank that becomes active. A swap in the
    // first cycle after reset takes precedence over the bank-0 reload.
    always_comb begin
        len_d     = len_q;
        len_err_d = len_err_q;
        if (swap_fire) begin
            len_d     = hdr_vec[~bank_sel_q];
            len_err_d = len_bad(hdr_vec[~bank_sel_q]);
        end else if (init_q) begin
            len_d     = hdr_vec[0];
            len_err_d = len_bad(hdr_vec[0]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bank_sel_q     <= 1'b0;
            swap_pending_q <= 1'b0;
            state_q        <= ST_IDLE;
            elapsed_q      <= '0;
            trig_miss_q    <= '0;
            len_q          <= '0;
            len_err_q      <= 1'b0;
            init_q         <= 1'b1;
        end else begin
            bank_sel_q     <= bank_sel_d;
            swap_pending_q <= swap_pending_d;
            state_q        <= state_d;
            elapsed_q      <= elapsed_d;
            trig_miss_q    <= trig_miss_d;
            len_q          <= len_d;
            len_err_q      <= len_err_d;
            init_q         <= 1'b0;
        end
    end

    assign mem          = mem_q;
    assign start        = (state_q == ST_LAUNCH);
    assign busy         = busy_w;
    assign bank_sel     = bank_sel_q;
    assign swap_pending = swap_pending_q;
    assign len_err      = len_err_q;
    assign trig_miss    = trig_miss_q;

endmodule

// File: tb/tb_ff_table_bank.sv
// ---------------------------------------------------------------------------
// tb_ff_table_bank
//
// Drives ff_table_bank through directed scenarios (load, playback, deferred
// swap, collisions, rejections, reset mid-play) followed by a randomized
// phase. A behavioural model tracks both banks as plain arrays and playback
// as a cycle count since start; every DUT output is compared to it after
// each clock once the banks hold known data.
// ---------------------------------------------------------------------------
module tb_ff_table_bank;

    localparam int MEM_AW = 11;
    localparam int DW     = 18;
    localparam int MISS_W = 8;
    localparam int DEPTH  = 1 << MEM_AW;
    localparam int MISS_MAX = (1 << MISS_W) - 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              lb_write;
    logic [MEM_AW-1:0] lb_addr;
    logic [DW-1:0]     lb_data;
    logic              commit;
    logic              arm;
    logic              trig;
    logic [MEM_AW-1:0] mem_addr;
    logic [DW-1:0]     mem;
    logic              start;
    logic              busy;
    logic              bank_sel;
    logic              swap_pending;
    logic              len_err;
    logic [MISS_W-1:0] trig_miss;

    always #5 clk = ~clk;

    ff_table_bank #(
        .MEM_AW (MEM_AW),
        .DW     (DW),
        .MISS_W (MISS_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .lb_write     (lb_write),
        .lb_addr      (lb_addr),
        .lb_data      (lb_data),
        .commit       (commit),
        .arm          (arm),
        .trig         (trig),
        .mem_addr     (mem_addr),
        .mem          (mem),
        .start        (start),
        .busy         (busy),
        .bank_sel     (bank_sel),
        .swap_pending (swap_pending),
        .len_err      (len_err),
        .trig_miss    (trig_miss)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit checks_on = 1'b0;

    // Behavioural reference
    int m_bank [2][DEPTH];
    int m_sel, m_pend, m_since, m_miss, m_mem, m_len, m_lenerr, m_init;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int bad_len(input int l);
        return ((l < 4) || (l == DEPTH - 1)) ? 1 : 0;
    endfunction

    // One clock of the reference, using the inputs sampled at this edge.
    task automatic model_step();
        int  rd;
        bit  playing, swap, acc;
        if (reset) begin
            m_sel = 0; m_pend = 0; m_since = -1; m_miss = 0;
            m_mem = 0; m_len = 0; m_lenerr = 0; m_init = 1;
            return;
        end
        rd      = m_bank[m_sel][mem_addr];
        playing = (m_since >= 0);
        swap    = (m_pend != 0 || commit) && !playing && !lb_write;
        acc     = trig && arm && (m_lenerr == 0) && !playing && !swap;
        if (trig && !acc && m_miss < MISS_MAX) m_miss++;
        if (!playing)                                    m_since = acc ? 0 : -1;
        else if (m_since >= 4 && int'(mem_addr) == m_len) m_since = -1;
        else                                             m_since++;
        if (lb_write) m_bank[1 - m_sel][lb_addr] = int'(lb_data);
        if (swap) begin
            m_sel    = 1 - m_sel;
            m_pend   = 0;
            m_len    = m_bank[m_sel][0] % DEPTH;
            m_lenerr = bad_len(m_len);
        end else begin
            if (commit) m_pend = 1;
            if (m_init != 0) begin
                m_len    = m_bank[0][0] % DEPTH;
                m_lenerr = bad_len(m_len);
            end
        end
        m_init = 0;
        m_mem  = rd;
    endtask

    task automatic compare_all();
        check_eq("mem",          32'(mem),          m_mem);
        check_eq("start",        32'(start),        (m_since == 0) ? 1 : 0);
        check_eq("busy",         32'(busy),         (m_since >= 0) ? 1 : 0);
        check_eq("bank_sel",     32'(bank_sel),     m_sel);
        check_eq("swap_pending", 32'(swap_pending), m_pend);
        check_eq("len_err",      32'(len_err),      m_lenerr);
        check_eq("trig_miss",    32'(trig_miss),    m_miss);
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        if (checks_on) compare_all();
    endtask

    task automatic host_write(input int a, input int d);
        lb_write = 1'b1;
        lb_addr  = MEM_AW'(a);
        lb_data  = DW'(d);
        step();
        lb_write = 1'b0;
    endtask

    task automatic sweep(input int from, input int to);
        for (int a = from; a <= to; a++) begin
            mem_addr = MEM_AW'(a);
            step();
        end
    endtask

    initial begin
        reset = 1'b1; lb_write = 1'b0; lb_addr = '0; lb_data = '0;
        commit = 1'b0; arm = 1'b0; trig = 1'b0; mem_addr = '0;
        for (int k = 0; k < DEPTH; k++) begin
            m_bank[0][k] = 0;
            m_bank[1][k] = 0;
        end
        repeat (3) step();
        check_eq("rst_mem",   32'(mem), 0);
        check_eq("rst_start", 32'(start), 0);
        check_eq("rst_busy",  32'(busy), 0);
        check_eq("rst_sel",   32'(bank_sel), 0);
        check_eq("rst_pend",  32'(swap_pending), 0);
        check_eq("rst_lenerr", 32'(len_err), 0);
        check_eq("rst_miss",  32'(trig_miss), 0);
        reset = 1'b0;

        // Load: fill shadow bank 1, header 15, words 1..15 = 100+k
        for (int a = 0; a < DEPTH; a++)
            host_write(a, (a == 0) ? 15 : (a < 16) ? 100 + a : int'($urandom_range(0, 262143)));
        commit = 1'b1; step(); commit = 1'b0;
        check_eq("load_sel",  32'(bank_sel), 1);
        check_eq("load_pend", 32'(swap_pending), 0);
        checks_on = 1'b1;
        mem_addr = 5; step();
        check_eq("load_mem5", 32'(mem), 105);

        // Fill bank 0 (now shadow): header 20, word 5 = 500
        for (int a = 0; a < DEPTH; a++)
            host_write(a, (a == 0) ? 20 : (a == 5) ? 500 : int'($urandom_range(0, 262143)));

        // Playback on bank 1
        arm = 1'b1; trig = 1'b1; step(); trig = 1'b0;
        check_eq("play_start", 32'(start), 1);
        check_eq("play_busy",  32'(busy), 1);
        mem_addr = 0; step();
        check_eq("play_start_once", 32'(start), 0);
        sweep(1, 14);
        check_eq("play_busy_mid", 32'(busy), 1);
        sweep(15, 15);
        check_eq("play_busy_end", 32'(busy), 0);
        check_eq("play_miss",     32'(trig_miss), 0);

        // Deferred swap: commit while busy, shadow write does not show on mem
        trig = 1'b1; step(); trig = 1'b0;
        commit = 1'b1; mem_addr = 0; step(); commit = 1'b0;
        check_eq("defer_pend", 32'(swap_pending), 1);
        check_eq("defer_sel",  32'(bank_sel), 1);
        mem_addr = 5; host_write(5, 777); step();
        check_eq("defer_mem_isolated", 32'(mem), 105);
        sweep(6, 15);
        check_eq("defer_busy_end", 32'(busy), 0);
        check_eq("defer_sel_hold", 32'(bank_sel), 1);
        mem_addr = 5; step();
        check_eq("defer_sel_swapped", 32'(bank_sel), 0);
        step();
        check_eq("defer_mem_new", 32'(mem), 777);

        // Collision: lb_write held after playback stalls the swap
        trig = 1'b1; step(); trig = 1'b0;
        commit = 1'b1; mem_addr = 0; step(); commit = 1'b0;
        sweep(1, 20);
        check_eq("coll_busy_end", 32'(busy), 0);
        lb_write = 1'b1;
        for (int k = 0; k < 3; k++) begin
            lb_addr = MEM_AW'(100 + k); lb_data = DW'($urandom_range(0, 262143));
            step();
            check_eq("coll_hold_pend", 32'(swap_pending), 1);
            check_eq("coll_hold_sel",  32'(bank_sel), 0);
        end
        lb_write = 1'b0; trig = 1'b1; step(); trig = 1'b0;
        check_eq("coll_no_start", 32'(start), 0);
        check_eq("coll_miss",     32'(trig_miss), 1);
        check_eq("coll_sel",      32'(bank_sel), 1);

        // Rejections: arm=0, trig while playing, invalid header
        arm = 1'b0; trig = 1'b1; step(); trig = 1'b0; arm = 1'b1;
        check_eq("rej_arm_start", 32'(start), 0);
        check_eq("rej_arm_miss",  32'(trig_miss), 2);
        trig = 1'b1; step(); trig = 1'b0;
        check_eq("rej_play_launch", 32'(start), 1);
        mem_addr = 0; step();
        mem_addr = 1; trig = 1'b1; step(); trig = 1'b0;
        check_eq("rej_play_start", 32'(start), 0);
        check_eq("rej_play_miss",  32'(trig_miss), 3);
        sweep(2, 15);
        check_eq("rej_play_end", 32'(busy), 0);
        host_write(0, 2);
        commit = 1'b1; step(); commit = 1'b0;
        check_eq("rej_len_err", 32'(len_err), 1);
        trig = 1'b1; step(); trig = 1'b0;
        check_eq("rej_len_start", 32'(start), 0);
        check_eq("rej_len_miss",  32'(trig_miss), 4);
        for (int k = 0; k < 300; k++) begin
            trig = 1'b1; step(); trig = 1'b0; step();
        end
        check_eq("miss_saturate", 32'(trig_miss), MISS_MAX);

        // Reset mid-play with a swap pending
        commit = 1'b1; step(); commit = 1'b0;
        step();
        trig = 1'b1; step(); trig = 1'b0;
        commit = 1'b1; mem_addr = 0; step(); commit = 1'b0;
        step();
        check_eq("pre_rst_pend", 32'(swap_pending), 1);
        reset = 1'b1; step(); reset = 1'b0;
        check_eq("midrst_busy", 32'(busy), 0);
        check_eq("midrst_pend", 32'(swap_pending), 0);
        check_eq("midrst_sel",  32'(bank_sel), 0);
        check_eq("midrst_miss", 32'(trig_miss), 0);
        mem_addr = 5; step(); step();
        check_eq("midrst_mem_kept", 32'(mem), 777);
        check_eq("midrst_len_err",  32'(len_err), 1);

        // Randomized phase
        for (int i = 0; i < 3000; i++) begin
            reset    = ($urandom_range(0, 599) == 0);
            lb_write = !reset && ($urandom_range(0, 3) == 0);
            lb_addr  = MEM_AW'($urandom_range(0, 31));
            if (lb_addr == '0)
                lb_data = ($urandom_range(0, 9) == 0) ? DW'(DEPTH - 1) : DW'($urandom_range(0, 24));
            else
                lb_data = DW'($urandom_range(0, 262143));
            commit   = ($urandom_range(0, 19) == 0);
            arm      = ($urandom_range(0, 7) != 0);
            trig     = ($urandom_range(0, 9) == 0);
            mem_addr = MEM_AW'($urandom_range(0, 31));
            step();
        end
        reset = 1'b0; lb_write = 1'b0; commit = 1'b0; trig = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
